// File: rtl/conv_controller.sv
// Control FSM for a streaming KxK convolution: loads the kernel weights, then streams
// the pixels in raster order and emits one window result per valid output position.
module conv_controller #(
  parameter int KERNEL_SIZE = 5,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int CW          = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          weight_valid,
  output logic          weight_ready,
  input  logic          pixel_valid,
  output logic          pixel_ready,
  output logic          weight_write,
  output logic [CW-1:0] weight_index,
  output logic          write,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] LastTap = CW'(KERNEL_SIZE * KERNEL_SIZE - 1);
  localparam logic [CW-1:0] LastCol = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] LastRow = CW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] KOff    = CW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] widx_q, widx_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] orow_q, orow_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic          ovalid_q, ovalid_d;
  logic          pixDone_q, pixDone_d;
  logic          resultHs;

  assign resultHs = ovalid_q & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving STREAM waits until the last pixel is in and its result has drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (weight_write && widx_q == LastTap) state_d = STREAM;
      STREAM:  if (pixDone_q && (!ovalid_q || out_ready)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    weight_ready = !reset && (state_q == LOAD_W);
    weight_write = weight_ready && weight_valid;
    pixel_ready  = !reset && (state_q == STREAM) && !pixDone_q && !(ovalid_q && !out_ready);
    write        = pixel_ready && pixel_valid;
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    weight_index = widx_q;
    out_valid    = ovalid_q;
    out_row      = orow_q;
    out_col      = ocol_q;
  end

  always_comb begin
    widx_d    = widx_q;
    col_d     = col_q;
    row_d     = row_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    ovalid_d  = ovalid_q;
    pixDone_d = pixDone_q;
    if (state_q == IDLE && start) begin
      widx_d    = '0;
      col_d     = '0;
      row_d     = '0;
      ovalid_d  = 1'b0;
      pixDone_d = 1'b0;
    end
    if (weight_write) begin
      widx_d = (widx_q == LastTap) ? '0 : widx_q + CW'(1);
    end
    if (write) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = row_q + CW'(1);
        if (row_q == LastRow) pixDone_d = 1'b1;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // A new qualifying pixel overrides the drain so results can go back to back.
    if (write && col_q >= KOff && row_q >= KOff) begin
      ovalid_d = 1'b1;
      orow_d   = row_q - KOff;
      ocol_d   = col_q - KOff;
    end else if (resultHs) begin
      ovalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      ovalid_q  <= 1'b0;
      pixDone_q <= 1'b0;
    end else begin
      widx_q    <= widx_d;
      col_q     <= col_d;
      row_q     <= row_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      ovalid_q  <= ovalid_d;
      pixDone_q <= pixDone_d;
    end
  end

endmodule

// File: tb/tb_conv_controller.sv
// Randomized bench for conv_controller: an 8x8/K=5 instance checked every cycle against a
// count-based reference model, plus a default 28x28 instance checked for result order and count.
module tb_conv_controller;

  localparam int K    = 5;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int CW   = 5;
  localparam int KK   = K * K;
  localparam int NPIX = W * H;
  localparam int OW   = W - K + 1;
  localparam int BOW  = 28 - K + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, weight_valid, pixel_valid, out_ready;
  logic          weight_ready, pixel_ready, weight_write, write, out_valid, busy, done;
  logic [CW-1:0] weight_index, out_row, out_col;

  logic          bReset, bStart, bWeightValid, bPixelValid, bOutReady;
  logic          bWeightReady, bPixelReady, bWeightWrite, bWrite, bOutValid, bBusy, bDone;
  logic [4:0]    bWeightIndex, bOutRow, bOutCol;

  conv_controller #(.KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .weight_valid(weight_valid), .weight_ready(weight_ready),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .weight_write(weight_write), .weight_index(weight_index), .write(write),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  conv_controller bigDut (
    .clk(clk), .reset(bReset), .start(bStart),
    .weight_valid(bWeightValid), .weight_ready(bWeightReady),
    .pixel_valid(bPixelValid), .pixel_ready(bPixelReady),
    .weight_write(bWeightWrite), .weight_index(bWeightIndex), .write(bWrite),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_row(bOutRow), .out_col(bOutCol),
    .busy(bBusy), .done(bDone)
  );

  int nCompared = 0;
  int nMismatched = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic wv, input logic pv, input logic rdy);
    start        = s;
    weight_valid = wv;
    pixel_valid  = pv;
    out_ready    = rdy;
  endtask

  // Reference model: frame progress kept as plain counts of accepted weights and pixels.
  bit mActive, mDone, mJustReset, mPend;
  int mWCnt, mPCnt, mPRow, mPCol, mResCnt;
  int obsWw, obsWr, obsRes, obsDone, obsFirstRow, obsFirstCol, obsLastRow, obsLastCol;

  always @(negedge clk) begin : modelCompare
    bit eWReady, ePReady, pHs, rHs, finish, startOk;
    int r, c;
    if (reset) begin
      mActive = 0; mDone = 0; mJustReset = 1; mPend = 0;
      mWCnt = 0; mPCnt = 0; mResCnt = 0;
    end else begin
      eWReady = mActive && mWCnt < KK;
      ePReady = mActive && mWCnt == KK && mPCnt < NPIX && !(mPend && !out_ready);
      checkOutput("busy", busy, int'(mActive || mDone));
      checkOutput("done", done, int'(mDone));
      checkOutput("weight_ready", weight_ready, int'(eWReady));
      checkOutput("weight_write", weight_write, int'(eWReady && weight_valid));
      checkOutput("pixel_ready", pixel_ready, int'(ePReady));
      checkOutput("write", write, int'(ePReady && pixel_valid));
      checkOutput("out_valid", out_valid, int'(mPend));
      if (eWReady) checkOutput("weight_index", weight_index, mWCnt);
      if (mJustReset) checkOutput("weight_index_rst", weight_index, 0);
      if (mPend || mJustReset) begin
        checkOutput("out_row", out_row, mPend ? mPRow : 0);
        checkOutput("out_col", out_col, mPend ? mPCol : 0);
      end
      if (weight_write) obsWw++;
      if (write) obsWr++;
      if (done) obsDone++;
      if (out_valid && out_ready) begin
        checkOutput("raster_row", out_row, mResCnt / OW);
        checkOutput("raster_col", out_col, mResCnt % OW);
        if (obsRes == 0) begin
          obsFirstRow = out_row;
          obsFirstCol = out_col;
        end
        obsLastRow = out_row;
        obsLastCol = out_col;
        obsRes++;
      end
      startOk = !mActive && !mDone && start;
      finish  = mActive && mPCnt == NPIX && (!mPend || out_ready);
      pHs     = ePReady && pixel_valid;
      rHs     = mPend && out_ready;
      mJustReset = 0;
      if (eWReady && weight_valid) mWCnt++;
      if (rHs) begin
        mPend = 0;
        mResCnt++;
      end
      if (pHs) begin
        r = mPCnt / W;
        c = mPCnt % W;
        if (r >= K - 1 && c >= K - 1) begin
          mPend = 1;
          mPRow = r - (K - 1);
          mPCol = c - (K - 1);
        end
        mPCnt++;
      end
      mDone = finish;
      if (finish) mActive = 0;
      if (startOk) begin
        mActive = 1; mWCnt = 0; mPCnt = 0; mPend = 0; mResCnt = 0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int bWw, bWr, bRes, bDoneCnt, bLastHs, bLastRow, bLastCol;

  always @(negedge clk) begin : bigCompare
    if (!bReset) begin
      if (bWeightWrite) bWw++;
      if (bWrite) bWr++;
      if (bOutValid && bOutReady) begin
        checkOutput("big_row", bOutRow, bRes / BOW);
        checkOutput("big_col", bOutCol, bRes % BOW);
        bLastHs  = cyc;
        bLastRow = bOutRow;
        bLastCol = bOutCol;
        bRes++;
      end
      if (bDone) begin
        bDoneCnt++;
        checkOutput("big_done_latency", cyc - bLastHs, 1);
      end
    end
  end

  // mode 0: out_ready held high; mode 1: random backpressure, one 10-cycle stall, stray starts.
  task automatic runFrame(input int mode, input int abortAt, output bit aborted);
    int stallLeft;
    bit stalled, finished;
    obsWw = 0; obsWr = 0; obsRes = 0; obsDone = 0;
    obsFirstRow = -1; obsFirstCol = -1; obsLastRow = -1; obsLastCol = -1;
    aborted = 0; finished = 0; stallLeft = 0; stalled = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        finished = 1;
        break;
      end
      if (abortAt > 0 && obsWr >= abortAt) begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        aborted = 1;
        break;
      end
      weight_valid = 1'($urandom_range(0, 1));
      pixel_valid  = ($urandom_range(0, 3) != 0);
      if (mode == 0) begin
        out_ready = 1'b1;
      end else begin
        if (!stalled && out_valid) begin
          stallLeft = 10;
          stalled = 1;
        end
        if (stallLeft > 0) begin
          out_ready = 1'b0;
          stallLeft--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
        start = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    if (!finished && !aborted) checkOutput("frame_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit aborted;
    bit bFinished;
    reset = 1'b1;
    bReset = 1'b1;
    bStart = 1'b0; bWeightValid = 1'b0; bPixelValid = 1'b0; bOutReady = 1'b1;
    bWw = 0; bWr = 0; bRes = 0; bDoneCnt = 0; bLastHs = 0; bLastRow = -1; bLastCol = -1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    bReset = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_weight_ready", weight_ready, 0);
    @(posedge clk); #1;

    runFrame(0, 0, aborted);
    checkOutput("f1_weight_writes", obsWw, 25);
    checkOutput("f1_writes", obsWr, 64);
    checkOutput("f1_results", obsRes, 16);
    checkOutput("f1_done_pulses", obsDone, 1);
    checkOutput("f1_first_row", obsFirstRow, 0);
    checkOutput("f1_first_col", obsFirstCol, 0);
    checkOutput("f1_last_row", obsLastRow, 3);
    checkOutput("f1_last_col", obsLastCol, 3);

    runFrame(1, 0, aborted);
    checkOutput("f2_results", obsRes, 16);
    checkOutput("f2_writes", obsWr, 64);
    checkOutput("f2_done_pulses", obsDone, 1);

    runFrame(0, 30, aborted);
    checkOutput("f3_aborted", int'(aborted), 1);
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_pixel_ready", pixel_ready, 0);
    @(posedge clk); #1;

    runFrame(0, 0, aborted);
    checkOutput("f4_weight_writes", obsWw, 25);
    checkOutput("f4_results", obsRes, 16);
    checkOutput("f4_done_pulses", obsDone, 1);

    bFinished = 0;
    bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bDone) begin
        bFinished = 1;
        break;
      end
      bWeightValid = 1'($urandom_range(0, 1));
      bPixelValid  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bWeightValid = 1'b0;
    bPixelValid  = 1'b0;
    if (!bFinished) checkOutput("big_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("big_weight_writes", bWw, 25);
    checkOutput("big_writes", bWr, 784);
    checkOutput("big_results", bRes, 576);
    checkOutput("big_last_row", bLastRow, 23);
    checkOutput("big_last_col", bLastCol, 23);
    checkOutput("big_done_pulses", bDoneCnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
